// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide unit
//
// Purpose: controller state encoding and default operand width, shared by
//          multdiv_unit and its testbench.
// Contents:
//    DEFAULT_WIDTH - default operand/result width in bits
//    state_t       - controller states IDLE, MULT, DIV, DONE
package multdiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - iteration up-counter with terminal-count flag
//
// Purpose: counts datapath iterations; terminal is high while the count equals
//          LAST, so the controller leaves the iterate state on that edge.
// Ports:
//    clock    in   rising-edge clock
//    reset    in   asynchronous active-high reset (count -> 0)
//    clear    in   synchronous clear, wins over enable
//    enable   in   increment by one
//    terminal out  count == LAST
module multdiv_counter #(
   parameter int CW   = 6,
   parameter int LAST = 31
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign terminal = (count == CW'(LAST));

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply / divide unit
//
// Purpose: signed WIDTH x WIDTH multiply (low half of product, overflow flag)
//          and signed divide (quotient truncated toward zero), one shift-add or
//          restoring step per cycle, fixed WIDTH+1 cycle latency.
// Ports:
//    clock           in   rising-edge clock
//    reset           in   asynchronous active-high reset
//    data_operandA   in   multiplicand / dividend (signed)
//    data_operandB   in   multiplier / divisor (signed)
//    ctrl_MULT       in   start pulse, multiply (wins over ctrl_DIV)
//    ctrl_DIV        in   start pulse, divide
//    data_result     out  product low half or quotient, held until next result
//    data_exception  out  multiply overflow, divide by zero, or MIN / -1
//    data_resultRDY  out  one-cycle pulse when data_result is updated
//    busy            out  high while iterating
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

   state_t state, state_next;

   logic                 start;
   logic                 iter_last;
   // Both operations run on magnitudes; acc_hi/acc_lo form the 2*WIDTH
   // product register for multiply and the remainder/quotient pair for divide.
   logic [WIDTH-1:0]     acc_hi, acc_lo, mcand;
   logic                 op_div, neg_res, div_zero, div_ovf;

   logic [WIDTH:0]       add_a, add_b, add_sum;
   logic                 add_sub;
   logic [WIDTH-1:0]     div_shift;
   logic [2*WIDTH-1:0]   prod_mag, prod_signed;
   logic [WIDTH:0]       prod_top;
   logic [WIDTH-1:0]     quot_signed;
   logic                 mult_ovf;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign start = ctrl_MULT | ctrl_DIV;
   assign busy  = (state == MULT) || (state == DIV);

   multdiv_counter #(
      .CW   (CW),
      .LAST (WIDTH - 1)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (start),
      .enable   (busy),
      .terminal (iter_last)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (ctrl_MULT) begin
         state_next = MULT;
      end else if (ctrl_DIV) begin
         state_next = DIV;
      end else begin
         case (state)
            MULT, DIV: if (iter_last) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
         endcase
      end
   end

   // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so the
   // shifted remainder always fits in WIDTH bits and acc_hi's MSB is spare.
   assign div_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};

   // Single shared adder: add multiplicand in MULT, subtract divisor in DIV.
   always_comb begin
      add_sub = 1'b0;
      add_a   = {1'b0, acc_hi};
      add_b   = {1'b0, mcand};
      if (state == DIV) begin
         add_sub = 1'b1;
         add_a   = {1'b0, div_shift};
      end
      add_sum = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
   end

   assign prod_mag    = {acc_hi, acc_lo};
   assign prod_signed = neg_res ? -prod_mag : prod_mag;
   // Representable iff the upper WIDTH+1 bits are a pure sign extension.
   assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
   assign mult_ovf    = !((&prod_top) || !(|prod_top));
   assign quot_signed = neg_res ? -acc_lo : acc_lo;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_hi         <= '0;
         acc_lo         <= '0;
         mcand          <= '0;
         op_div         <= 1'b0;
         neg_res        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            acc_hi   <= '0;
            acc_lo   <= magnitude(data_operandA);
            mcand    <= magnitude(data_operandB);
            op_div   <= !ctrl_MULT;
            neg_res  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == MOST_NEG) && (data_operandB == MINUS_ONE);
         end else begin
            case (state)
               MULT: begin
                  if (acc_lo[0]) begin
                     acc_hi <= add_sum[WIDTH:1];
                     acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                  end else begin
                     acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
                     acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
                  end
               end
               DIV: begin
                  // Non-negative difference means the divisor fits: keep it.
                  acc_hi <= add_sum[WIDTH] ? div_shift : add_sum[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], ~add_sum[WIDTH]};
               end
               DONE: begin
                  data_resultRDY <= 1'b1;
                  if (op_div) begin
                     data_result    <= div_zero ? '0 : quot_signed;
                     data_exception <= div_zero | div_ovf;
                  end else begin
                     data_result    <= prod_signed[WIDTH-1:0];
                     data_exception <= mult_ovf;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - self-checking bench for multdiv_unit (WIDTH=32)
module tb_multdiv_unit;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  data_operandA = '0;
   logic [W-1:0]  data_operandB = '0;
   logic          ctrl_MULT = 1'b0;
   logic          ctrl_DIV = 1'b0;
   logic [W-1:0]  data_result;
   logic          data_exception;
   logic          data_resultRDY;
   logic          busy;

   int checks = 0;
   int errors = 0;

   multdiv_unit #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain signed arithmetic on 64-bit integers.
   task automatic ref_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
      longint p;
      int     sa, sb, lo;
      sa = $signed(a);
      sb = $signed(b);
      if (!is_div) begin
         p  = longint'(sa) * longint'(sb);
         lo = int'(p[31:0]);
         r  = p[31:0];
         e  = (longint'(lo) != p);
      end else if (sb == 0) begin
         r = '0;
         e = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         r = a;
         e = 1'b1;
      end else begin
         lo = sa / sb;
         r  = lo;
         e  = 1'b0;
      end
   endtask

   // Presents a start pulse sampled by the next rising edge (edge 0), then
   // scrambles the operand inputs to prove they were latched.
   task automatic issue(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Watches n edges after edge 0; records ready pulses and busy cycles.
   task automatic observe(input int n, output int rdy_cnt, output int rdy_edge,
                          output int busy_hi, output logic [W-1:0] res, output logic exc);
      rdy_cnt  = 0;
      rdy_edge = -1;
      busy_hi  = busy ? 1 : 0;
      res      = '0;
      exc      = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clock);
         #1;
         if (busy) busy_hi++;
         if (data_resultRDY) begin
            rdy_cnt++;
            if (rdy_edge < 0) begin
               rdy_edge = k;
               res      = data_result;
               exc      = data_exception;
            end
         end
      end
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h/%b/%b/%b want 0/0/0/0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_directed;
      logic         is_div [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] opa    [6] = '{32'd7, 32'h00010000, -32'sd43, 32'd7, 32'h80000000, 32'h80000000};
      logic [W-1:0] opb    [6] = '{-32'sd6, 32'h00010000, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [W-1:0] want_r, res;
      logic         want_e, exc;
      int           rc, re, bh;
      for (int i = 0; i < 6; i++) begin
         ref_op(is_div[i], opa[i], opb[i], want_r, want_e);
         issue(!is_div[i], is_div[i], opa[i], opb[i]);
         observe(W + 4, rc, re, bh, res, exc);
         checks++;
         if (res !== want_r) begin
            errors++;
            $display("FAIL dir%0d_result got %h want %h", i, res, want_r);
         end
         checks++;
         if (exc !== want_e) begin
            errors++;
            $display("FAIL dir%0d_exception got %b want %b", i, exc, want_e);
         end
         checks++;
         if (re != W + 1 || rc != 1) begin
            errors++;
            $display("FAIL dir%0d_latency got edge %0d count %0d want edge %0d count 1", i, re, rc, W + 1);
         end
         checks++;
         if (bh != W) begin
            errors++;
            $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bh, W);
         end
         checks++;
         if (data_result !== want_r || data_exception !== want_e) begin
            errors++;
            $display("FAIL dir%0d_hold got %h/%b want %h/%b", i, data_result, data_exception, want_r, want_e);
         end
      end
   endtask

   task automatic test_random(input logic is_div, input int n);
      logic [W-1:0] a, b, want_r, res;
      logic [15:0]  h;
      logic         want_e, exc;
      int           rc, re, bh;
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            h = 16'($urandom);
            a = {{16{h[15]}}, h};
         end
         case ($urandom_range(0, 5))
            0: b = is_div ? 32'd0 : b;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: begin h = 16'($urandom_range(0, 255)); b = {{8{h[7]}}, h[7:0], 16'h0} >>> 16; end
            default: ;
         endcase
         ref_op(is_div, a, b, want_r, want_e);
         issue(!is_div, is_div, a, b);
         observe(W + 2, rc, re, bh, res, exc);
         checks++;
         if (res !== want_r || exc !== want_e) begin
            errors++;
            $display("FAIL rand_%s a=%h b=%h got %h/%b want %h/%b",
                     is_div ? "div" : "mul", a, b, res, exc, want_r, want_e);
         end
         checks++;
         if (re != W + 1 || rc != 1) begin
            errors++;
            $display("FAIL rand_latency got edge %0d count %0d want edge %0d count 1", re, rc, W + 1);
         end
      end
   endtask

   task automatic test_priority;
      logic [W-1:0] res;
      logic         exc;
      int           rc, re, bh;
      issue(1'b1, 1'b1, 32'd6, 32'd3);
      observe(W + 2, rc, re, bh, res, exc);
      checks++;
      if (res !== 32'd18 || exc !== 1'b0 || rc != 1) begin
         errors++;
         $display("FAIL priority got %h/%b count %0d want 00000012/0 count 1", res, exc, rc);
      end
   endtask

   task automatic test_restart;
      logic [W-1:0] res;
      logic         exc;
      int           rc, re, bh, pre;
      pre = 0;
      issue(1'b1, 1'b0, 32'h12345, 32'h777);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) pre++;
      end
      issue(1'b0, 1'b1, 32'd100, 32'd7);
      observe(W + 6, rc, re, bh, res, exc);
      checks++;
      if (pre != 0 || rc != 1 || re + 5 != W + 6) begin
         errors++;
         $display("FAIL restart_ready got pre %0d count %0d edge %0d want 0 1 %0d", pre, rc, re + 5, W + 6);
      end
      checks++;
      if (res !== 32'd14 || exc !== 1'b0) begin
         errors++;
         $display("FAIL restart_result got %h/%b want 0000000e/0", res, exc);
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] res;
      logic         exc;
      int           rc, re, bh;
      issue(1'b0, 1'b1, 32'd100, 32'd7);
      repeat (10) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({data_result, data_exception, data_resultRDY, busy} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got %h/%b/%b/%b want 0/0/0/0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      #1 reset = 1'b0;
      observe(40, rc, re, bh, res, exc);
      checks++;
      if (rc != 0 || bh != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet got ready %0d busy %0d want 0 0", rc, bh);
      end
   endtask

   task automatic test_start_in_reset;
      logic [W-1:0] res;
      logic         exc;
      int           rc, re, bh;
      @(negedge clock);
      reset         = 1'b1;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd3;
      data_operandB = 32'd4;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      observe(40, rc, re, bh, res, exc);
      checks++;
      if (rc != 0 || bh != 0) begin
         errors++;
         $display("FAIL start_in_reset got ready %0d busy %0d want 0 0", rc, bh);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(1'b0, 20);
      test_random(1'b1, 20);
      test_priority();
      test_restart();
      test_reset_mid();
      test_start_in_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width in bits, legal range 4..64.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_operandA  input  WIDTH  signed multiplicand or dividend.
REQ-005 SHALL have port data_operandB  input  WIDTH  signed multiplier or divisor.
REQ-006 SHALL have port ctrl_MULT  input  1  one-cycle start pulse for a multiply.
REQ-007 SHALL have port ctrl_DIV  input  1  one-cycle start pulse for a divide.
REQ-008 SHALL have port data_result  output  WIDTH  signed product (low WIDTH bits) or quotient.
REQ-009 SHALL have port data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight (states MULT, DIV).

Function
REQ-012 SHALL implement states IDLE, MULT, DIV, DONE; IDLE->MULT on ctrl_MULT, IDLE->DIV on ctrl_DIV, MULT/DIV->DONE after WIDTH iterations, DONE->IDLE after one cycle.
REQ-013 SHALL latch both operands on the edge that samples a start pulse; operand inputs are don't-care afterwards.
REQ-014 SHALL, with ctrl_MULT and ctrl_DIV both high on the same edge, give ctrl_MULT priority.
REQ-015 SHALL, on a start pulse in any state (MULT, DIV, DONE included), abandon the current operation and restart with the new one; the abandoned operation never asserts data_resultRDY.
REQ-016 SHALL perform one shift-add (multiply) or one restoring step (divide) per cycle, counted by an iteration counter of width clog2(WIDTH+1).
REQ-017 SHALL have fixed latency: start sampled at edge 0, iterations on edges 1..WIDTH, result registered and data_resultRDY=1 on edge WIDTH+1, data_resultRDY=0 on edge WIDTH+2.
REQ-018 SHALL compute multiply as signed two's complement; data_result = low WIDTH bits of the 2*WIDTH product.
REQ-019 SHALL set data_exception on multiply when the 2*WIDTH product is not representable as a signed WIDTH-bit value.
REQ-020 SHALL compute divide on magnitudes, quotient truncated toward zero, sign = signA XOR signB, applied on edge WIDTH+1.
REQ-021 SHALL, on divide with data_operandB==0, give data_result=0, data_exception=1, same latency.
REQ-022 SHALL, on divide of most-negative by -1, give data_result=most-negative, data_exception=1.
REQ-023 SHALL hold data_result and data_exception stable from the data_resultRDY edge until the next data_resultRDY edge or reset.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-operation, immediately force state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 SHALL ignore start pulses on any edge where reset is high.

Structure
REQ-026 SHALL place the state enum (IDLE, MULT, DIV, DONE) and the default width constant in shared package multdiv_pkg.
REQ-027 SHALL instantiate one sub-module, multdiv_counter (parametrised up-counter with synchronous clear, async reset, terminal-count output), for iteration counting.
REQ-028 SHALL use one shared WIDTH+1-bit adder/subtractor for both multiply and divide steps.

Verification (WIDTH=32)
REQ-029 SHALL pass: ctrl_MULT, A=7, B=-6 -> data_resultRDY after edge 33, data_result=-42, data_exception=0, busy high edges 1..32.
REQ-030 SHALL pass: ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-031 SHALL pass: ctrl_DIV, A=-43, B=5 -> data_result=-8, data_exception=0; then ctrl_DIV, A=7, B=0 -> data_result=0, data_exception=1.
REQ-032 SHALL pass: ctrl_DIV, A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1.
REQ-033 SHALL pass: ctrl_MULT at edge 0, ctrl_DIV A=100, B=7 at edge 5 -> single data_resultRDY after edge 38, data_result=14, data_exception=0.
REQ-034 SHALL pass: ctrl_DIV A=100, B=7, reset pulsed between edges 10 and 11 -> all outputs 0 immediately, no data_resultRDY in the following 40 cycles.
